// File: rtl/uart_pkg.sv
// Shared constants for the parametrised UART receiver: the parity-mode codes,
// the frame FSM state encoding and the parity-error rule.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_DONE   = 3'd5,
        ST_BREAK  = 3'd6
    } state_e;

    // data_xor is the XOR of all received data bits; par_bit is the bit on the line.
    function automatic logic parity_error(input int mode, input logic data_xor,
                                          input logic par_bit);
        logic w_sum;
        w_sum = data_xor ^ par_bit;
        case (mode)
            PAR_ODD:  return ~w_sum;
            PAR_EVEN: return w_sum;
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_bit_sampler.sv
// Line front end: 2-FF synchroniser, falling-edge detect, per-bit tick counter
// and 3-sample majority vote around the middle of each bit.
module uart_bit_sampler
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_rxd,
    input  logic i_run,
    output logic o_rxd_s,
    output logic o_fall,
    output logic o_sample_strobe,
    output logic o_sample_bit,
    output logic o_bit_end
);

    localparam int MID    = CLKS_PER_BIT / 2;
    localparam int TICK_W = $clog2(CLKS_PER_BIT);

    logic [1:0]        r_sync;
    logic              r_prev;
    logic [TICK_W-1:0] r_tick;
    logic              r_s0;
    logic              r_s1;
    logic              w_rxd_s;

    assign w_rxd_s = r_sync[1];

    // NOTE: the synchroniser and edge history reset to 1 (idle line) so that
    // leaving reset can never look like a start-bit edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= 2'b11;
            r_prev <= 1'b1;
            r_tick <= '0;
            r_s0   <= 1'b1;
            r_s1   <= 1'b1;
        end else begin
            r_sync <= {r_sync[0], i_rxd};
            r_prev <= w_rxd_s;
            if (!i_run || r_tick == TICK_W'(CLKS_PER_BIT - 1)) begin
                r_tick <= '0;
            end else begin
                r_tick <= r_tick + 1'b1;
            end
            if (r_tick == TICK_W'(MID - 1)) r_s0 <= w_rxd_s;
            if (r_tick == TICK_W'(MID))     r_s1 <= w_rxd_s;
        end
    end

    // The third vote is the live sample at tick MID+1, so the decision is ready that cycle.
    assign o_rxd_s         = w_rxd_s;
    assign o_fall          = r_prev & ~w_rxd_s;
    assign o_sample_bit    = (r_s0 & r_s1) | (r_s0 & w_rxd_s) | (r_s1 & w_rxd_s);
    assign o_sample_strobe = i_run && (r_tick == TICK_W'(MID + 1));
    assign o_bit_end       = i_run && (r_tick == TICK_W'(CLKS_PER_BIT - 1));

endmodule

// File: rtl/uart_rx_frame.sv
// Parametrised UART receiver: frame FSM, error flags and the wrapping
// frame-buffer write address.
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = PAR_NONE,
    parameter int STOP_BITS    = 1,
    parameter int ADDR_DEPTH   = 30000,
    parameter int ADDR_W       = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rxd,
    input  logic                 addr_clr,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_flag,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err,
    output logic [ADDR_W-1:0]    rx_addr,
    output logic                 busy
);

    localparam int BIT_W = $clog2(DATA_BITS);

    state_e               r_state;
    logic                 r_busy;
    logic [DATA_BITS-1:0] r_shift;
    logic [BIT_W-1:0]     r_bit_cnt;
    logic                 r_stop_cnt;
    logic                 r_par_acc;
    logic                 r_perr;
    logic                 r_ferr;
    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_rx_flag;
    logic                 r_rx_parity_err;
    logic                 r_rx_frame_err;
    logic [ADDR_W-1:0]    r_addr;

    logic w_run;
    logic w_rxd_s;
    logic w_fall;
    logic w_strobe;
    logic w_bit;
    logic w_bit_end;
    logic w_stop_bit_err;

    assign w_run = (r_state == ST_START) || (r_state == ST_DATA) ||
                   (r_state == ST_PARITY) || (r_state == ST_STOP);
    assign w_stop_bit_err = r_ferr | ~w_bit;

    uart_bit_sampler #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_sampler (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_rxd          (rxd),
        .i_run          (w_run),
        .o_rxd_s        (w_rxd_s),
        .o_fall         (w_fall),
        .o_sample_strobe(w_strobe),
        .o_sample_bit   (w_bit),
        .o_bit_end      (w_bit_end)
    );

    // NOTE: all state uses non-blocking assignments so every branch reads the
    // pre-edge values, regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= ST_IDLE;
            r_busy          <= 1'b0;
            r_shift         <= '0;
            r_bit_cnt       <= '0;
            r_stop_cnt      <= 1'b0;
            r_par_acc       <= 1'b0;
            r_perr          <= 1'b0;
            r_ferr          <= 1'b0;
            r_rx_data       <= '0;
            r_rx_flag       <= 1'b0;
            r_rx_parity_err <= 1'b0;
            r_rx_frame_err  <= 1'b0;
        end else begin
            r_rx_flag       <= 1'b0;
            r_rx_parity_err <= 1'b0;
            r_rx_frame_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_fall) begin
                        r_state    <= ST_START;
                        r_busy     <= 1'b1;
                        r_bit_cnt  <= '0;
                        r_stop_cnt <= 1'b0;
                        r_par_acc  <= 1'b0;
                        r_perr     <= 1'b0;
                        r_ferr     <= 1'b0;
                    end
                end
                ST_START: begin
                    if (w_strobe && w_bit) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else if (w_bit_end) begin
                        r_state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_strobe) begin
                        r_shift   <= {w_bit, r_shift[DATA_BITS-1:1]};
                        r_par_acc <= r_par_acc ^ w_bit;
                    end
                    if (w_bit_end) begin
                        if (r_bit_cnt == BIT_W'(DATA_BITS - 1)) begin
                            r_state <= (PARITY_MODE == PAR_NONE) ? ST_STOP : ST_PARITY;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (w_strobe) r_perr <= parity_error(PARITY_MODE, r_par_acc, w_bit);
                    if (w_bit_end) r_state <= ST_STOP;
                end
                ST_STOP: begin
                    // The last stop sample completes the frame; the rest of that bit is not waited for.
                    if (w_strobe) begin
                        r_ferr <= w_stop_bit_err;
                        if (r_stop_cnt == 1'(STOP_BITS - 1)) begin
                            r_state         <= ST_DONE;
                            r_rx_data       <= r_shift;
                            r_rx_flag       <= 1'b1;
                            r_rx_parity_err <= r_perr;
                            r_rx_frame_err  <= w_stop_bit_err;
                        end else begin
                            r_stop_cnt <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (r_ferr) begin
                        r_state <= ST_BREAK;
                    end else begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                ST_BREAK: begin
                    if (w_rxd_s) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Only clean frames consume a buffer slot; a clear wins over the increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr <= '0;
        end else if (addr_clr) begin
            r_addr <= '0;
        end else if (r_rx_flag && !r_rx_parity_err && !r_rx_frame_err) begin
            if (r_addr == ADDR_W'(ADDR_DEPTH - 1)) begin
                r_addr <= '0;
            end else begin
                r_addr <= r_addr + 1'b1;
            end
        end
    end

    assign rx_data       = r_rx_data;
    assign rx_flag       = r_rx_flag;
    assign rx_parity_err = r_rx_parity_err;
    assign rx_frame_err  = r_rx_frame_err;
    assign rx_addr       = r_addr;
    assign busy          = r_busy;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Scoreboard bench for uart_rx_frame: three configurations driven with random
// frames, expectations computed from frame-level rules, checked on each rx_flag.
module tb_uart_rx_frame;

    localparam int CPB   [3] = '{16, 16, 10};
    localparam int DB    [3] = '{8, 7, 8};
    localparam int PM    [3] = '{0, 2, 1};
    localparam int SB    [3] = '{1, 1, 2};
    localparam int DEPTH [3] = '{30000, 30000, 5};

    typedef struct {
        logic [8:0] data;
        logic       perr;
        logic       ferr;
        int         addr;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic rxd_a, rxd_b, rxd_c;
    logic addr_clr_a, addr_clr_b, addr_clr_c;

    logic [7:0]  rx_data_a;
    logic [6:0]  rx_data_b;
    logic [7:0]  rx_data_c;
    logic        rx_flag_a, rx_flag_b, rx_flag_c;
    logic        perr_a, perr_b, perr_c;
    logic        ferr_a, ferr_b, ferr_c;
    logic [14:0] rx_addr_a, rx_addr_b;
    logic [2:0]  rx_addr_c;
    logic        busy_a, busy_b, busy_c;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t q_c[$];
    int   model_addr [3];
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   clr_arm = 1'b0;
    bit   clr_pending = 1'b0;

    always #5 clk = ~clk;

    uart_rx_frame u_dut_a (
        .clk(clk), .rst_n(rst_n), .rxd(rxd_a), .addr_clr(addr_clr_a),
        .rx_data(rx_data_a), .rx_flag(rx_flag_a), .rx_parity_err(perr_a),
        .rx_frame_err(ferr_a), .rx_addr(rx_addr_a), .busy(busy_a)
    );

    uart_rx_frame #(
        .DATA_BITS(7), .PARITY_MODE(2)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n), .rxd(rxd_b), .addr_clr(addr_clr_b),
        .rx_data(rx_data_b), .rx_flag(rx_flag_b), .rx_parity_err(perr_b),
        .rx_frame_err(ferr_b), .rx_addr(rx_addr_b), .busy(busy_b)
    );

    uart_rx_frame #(
        .CLKS_PER_BIT(10), .PARITY_MODE(1), .STOP_BITS(2), .ADDR_DEPTH(5), .ADDR_W(3)
    ) u_dut_c (
        .clk(clk), .rst_n(rst_n), .rxd(rxd_c), .addr_clr(addr_clr_c),
        .rx_data(rx_data_c), .rx_flag(rx_flag_c), .rx_parity_err(perr_c),
        .rx_frame_err(ferr_c), .rx_addr(rx_addr_c), .busy(busy_c)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic string tag(input int inst);
        return (inst == 0) ? "A" : (inst == 1) ? "B" : "C";
    endfunction

    function automatic int ones(input int inst, input logic [8:0] data);
        int n = 0;
        for (int i = 0; i < DB[inst]; i++) n += int'(data[i]);
        return n;
    endfunction

    // Parity bit that makes the frame legal for this instance.
    function automatic logic good_pbit(input int inst, input logic [8:0] data);
        logic odd_ones;
        odd_ones = ones(inst, data) % 2 == 1;
        return (PM[inst] == 1) ? ~odd_ones : odd_ones;
    endfunction

    task automatic set_rxd(input int inst, input logic b);
        case (inst)
            0:       rxd_a = b;
            1:       rxd_b = b;
            default: rxd_c = b;
        endcase
    endtask

    task automatic drive_bit(input int inst, input logic b);
        set_rxd(inst, b);
        repeat (CPB[inst]) @(negedge clk);
    endtask

    task automatic idle_bits(input int inst, input int n);
        for (int i = 0; i < n; i++) drive_bit(inst, 1'b1);
    endtask

    // Push the frame-level expectation, then put the frame on the line.
    task automatic send_frame(input int inst, input logic [8:0] data, input logic pbit,
                              input logic [1:0] stops);
        exp_t e;
        int   sum;
        sum    = ones(inst, data) + int'(pbit);
        e.data = data & 9'((1 << DB[inst]) - 1);
        e.perr = (PM[inst] == 1) ? (sum % 2 == 0) : (PM[inst] == 2) ? (sum % 2 == 1) : 1'b0;
        e.ferr = !stops[0] || (SB[inst] == 2 && !stops[1]);
        e.addr = model_addr[inst];
        if (!e.perr && !e.ferr) model_addr[inst] = (model_addr[inst] + 1) % DEPTH[inst];
        case (inst)
            0:       q_a.push_back(e);
            1:       q_b.push_back(e);
            default: q_c.push_back(e);
        endcase
        drive_bit(inst, 1'b0);
        for (int i = 0; i < DB[inst]; i++) drive_bit(inst, data[i]);
        if (PM[inst] != 0) drive_bit(inst, pbit);
        drive_bit(inst, stops[0]);
        if (SB[inst] == 2) drive_bit(inst, stops[1]);
    endtask

    task automatic send_clean(input int inst, input logic [8:0] data);
        send_frame(inst, data, good_pbit(inst, data), 2'b11);
    endtask

    task automatic handle(input int inst, input logic [8:0] data, input logic perr,
                          input logic ferr, input int addr);
        exp_t e;
        int   sz;
        sz = (inst == 0) ? q_a.size() : (inst == 1) ? q_b.size() : q_c.size();
        check({tag(inst), "_flag_expected"}, 32'(sz > 0), 32'd1);
        if (sz > 0) begin
            case (inst)
                0:       e = q_a.pop_front();
                1:       e = q_b.pop_front();
                default: e = q_c.pop_front();
            endcase
            check({tag(inst), "_rx_data"}, 32'(data), 32'(e.data));
            check({tag(inst), "_parity_err"}, 32'(perr), 32'(e.perr));
            check({tag(inst), "_frame_err"}, 32'(ferr), 32'(e.ferr));
            check({tag(inst), "_rx_addr"}, 32'(addr), 32'(e.addr));
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (rst_n && rx_flag_a) handle(0, 9'(rx_data_a), perr_a, ferr_a, int'(rx_addr_a));
    end

    initial forever begin
        @(negedge clk);
        if (rst_n && rx_flag_b) handle(1, 9'(rx_data_b), perr_b, ferr_b, int'(rx_addr_b));
    end

    // Instance C also exercises addr_clr coinciding with rx_flag.
    initial forever begin
        @(negedge clk);
        if (clr_pending) begin
            addr_clr_c  = 1'b0;
            clr_pending = 1'b0;
            check("C_addr_after_clr", 32'(rx_addr_c), 32'd0);
        end
        if (rst_n && rx_flag_c) begin
            handle(2, 9'(rx_data_c), perr_c, ferr_c, int'(rx_addr_c));
            if (clr_arm) begin
                addr_clr_c  = 1'b1;
                clr_arm     = 1'b0;
                clr_pending = 1'b1;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0] d;
        rst_n = 1'b0;
        rxd_a = 1'b1; rxd_b = 1'b1; rxd_c = 1'b1;
        addr_clr_a = 1'b0; addr_clr_b = 1'b0; addr_clr_c = 1'b0;
        for (int i = 0; i < 3; i++) model_addr[i] = 0;
        repeat (3) @(negedge clk);
        check("A_reset_data", 32'(rx_data_a), 32'd0);
        check("A_reset_flag", 32'(rx_flag_a), 32'd0);
        check("A_reset_addr", 32'(rx_addr_a), 32'd0);
        check("A_reset_busy", 32'(busy_a), 32'd0);
        check("C_reset_errs", 32'({perr_c, ferr_c}), 32'd0);
        rst_n = 1'b1;
        idle_bits(0, 2);

        // Instance A, 8N1: directed 0xA5 then random clean frames with random gaps.
        send_clean(0, 9'hA5);
        idle_bits(0, 1);
        check("A_addr_after_A5", 32'(rx_addr_a), 32'd1);
        for (int i = 0; i < 8; i++) begin
            send_clean(0, 9'($urandom_range(0, 255)));
            idle_bits(0, $urandom_range(0, 2));
        end
        idle_bits(0, 2);

        // Short low glitch: start is rejected, busy drops by tick MID+2.
        set_rxd(0, 1'b0);
        repeat (3) @(negedge clk);
        set_rxd(0, 1'b1);
        check("A_glitch_busy_high", 32'(busy_a), 32'd1);
        repeat (10) @(negedge clk);
        check("A_glitch_busy_low", 32'(busy_a), 32'd0);
        idle_bits(0, 2);

        // Stop bit low, then the line held low: one errored flag, then recovery.
        send_frame(0, 9'($urandom_range(0, 255)), 1'b0, 2'b00);
        repeat (40 * CPB[0]) @(negedge clk);
        check("A_break_busy", 32'(busy_a), 32'd1);
        idle_bits(0, 3);
        check("A_break_idle", 32'(busy_a), 32'd0);
        send_clean(0, 9'h3C);
        idle_bits(0, 2);

        // Instance B, 7E1: legal and illegal parity on 0x41, then random parity bits.
        send_frame(1, 9'h41, 1'b0, 2'b11);
        idle_bits(1, 1);
        send_frame(1, 9'h41, 1'b1, 2'b11);
        idle_bits(1, 1);
        check("B_addr_after_perr", 32'(rx_addr_b), 32'd1);
        for (int i = 0; i < 4; i++) begin
            send_frame(1, 9'($urandom_range(0, 127)), 1'($urandom_range(0, 1)), 2'b11);
            idle_bits(1, $urandom_range(0, 1));
        end
        idle_bits(1, 2);

        // Instance C, 8O2 at 10 clk/bit: back-to-back, address wrap, random errors.
        send_clean(2, 9'h00);
        send_clean(2, 9'hFF);
        for (int i = 0; i < 6; i++) begin
            send_clean(2, 9'($urandom_range(0, 255)));
            idle_bits(2, $urandom_range(0, 1));
        end
        for (int i = 0; i < 4; i++) begin
            send_frame(2, 9'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                       2'($urandom_range(0, 3)));
            idle_bits(2, $urandom_range(1, 2));
        end
        idle_bits(2, 2);

        // Clean frame with addr_clr on its flag cycle: clear wins over increment.
        clr_arm = 1'b1;
        send_clean(2, 9'h5A);
        idle_bits(2, 2);
        model_addr[2] = 0;
        send_clean(2, 9'h96);
        idle_bits(2, 2);

        // Reset in the middle of a frame: nothing is flagged, outputs clear.
        d = 9'h1B7;
        drive_bit(2, 1'b0);
        for (int i = 0; i < 3; i++) drive_bit(2, d[i]);
        rst_n = 1'b0;
        set_rxd(2, 1'b1);
        @(negedge clk);
        check("C_rst_data", 32'(rx_data_c), 32'd0);
        check("C_rst_flag", 32'(rx_flag_c), 32'd0);
        check("C_rst_addr", 32'(rx_addr_c), 32'd0);
        check("C_rst_busy", 32'(busy_c), 32'd0);
        check("A_rst_addr", 32'(rx_addr_a), 32'd0);
        for (int i = 0; i < 3; i++) model_addr[i] = 0;
        rst_n = 1'b1;
        idle_bits(2, 4);
        check("C_post_rst_busy", 32'(busy_c), 32'd0);
        send_clean(2, 9'hC3);
        idle_bits(2, 1);
        send_clean(0, 9'h81);
        idle_bits(0, 2);

        check("A_queue_drained", 32'(q_a.size()), 32'd0);
        check("B_queue_drained", 32'(q_b.size()), 32'd0);
        check("C_queue_drained", 32'(q_c.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_frame.md
Name: uart_rx_frame

Overview:
Parametrised UART receiver, successor to the fixed 8N1 16-clocks-per-bit receiver. Configurable divisor, data width, parity and stop bits; 2-FF input synchroniser, 3-sample majority vote, start-bit glitch rejection, parity/framing error flags. Keeps the wrapping write-address counter used to fill a downstream frame buffer, so it drops in as a direct replacement.

Parameters:
CLKS_PER_BIT, 16, clk cycles per bit; legal >= 8
DATA_BITS, 8, data bits per frame; legal 5..9
PARITY_MODE, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2
ADDR_DEPTH, 30000, rx_addr wraps from ADDR_DEPTH-1 to 0
ADDR_W, 15, rx_addr width; must satisfy 2**ADDR_W >= ADDR_DEPTH

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
rxd  in  1  serial line, asynchronous, idle high
addr_clr  in  1  synchronous clear of rx_addr
rx_data  out  DATA_BITS  last received word, LSB = first bit on line
rx_flag  out  1  one-cycle pulse: frame complete, rx_data/error flags valid
rx_parity_err  out  1  qualifies rx_flag; parity mismatch (0 when PARITY_MODE = 0)
rx_frame_err  out  1  qualifies rx_flag; any stop-bit sample low
rx_addr  out  ADDR_W  write address for the current frame
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset: all outputs 0; synchroniser flops reset to 1; state IDLE; counters 0.
- Synchroniser: rxd passes through 2 flops (rxd_s). All decisions use rxd_s. 2-cycle input latency.
- MID = CLKS_PER_BIT/2. Bit sample = majority of rxd_s at tick MID-1, MID, MID+1 of the bit period.
- Tick counter: 0..CLKS_PER_BIT-1 within each bit; bit counter: 0..DATA_BITS-1.
- States:
  - IDLE: falling edge of rxd_s (prev 1, now 0) -> START, tick = 0.
  - START: at tick MID+1, majority = 1 -> IDLE (glitch rejected, no flag). Otherwise continue; at tick CLKS_PER_BIT-1 -> DATA.
  - DATA: sampled bit shifts in LSB first. After bit DATA_BITS-1 ends -> PARITY if PARITY_MODE != 0, else STOP.
  - PARITY: parity error if XOR(data, parity bit) = 0 for odd, or = 1 for even. -> STOP at end of bit.
  - STOP: each stop bit sampled at MID+1; any 0 sets frame error. After the last stop bit's MID+1 sample -> DONE. No wait for the remainder of the stop bit, so back-to-back frames resynchronise.
  - DONE: one cycle. Update rx_data; pulse rx_flag; drive error flags for that cycle only. If frame_err -> BREAK, else IDLE.
  - BREAK: wait until rxd_s = 1, then IDLE. Line held low produces exactly one flagged frame.
- rx_data holds its value between flags.
- rx_addr: on rx_flag with both errors 0, increment; ADDR_DEPTH-1 wraps to 0. Errored frames do not advance. addr_clr has priority over increment. rx_addr is the address of the next frame; the downstream write uses the pre-increment value in the flag cycle.
- Frame latency: rx_flag rises 1 cycle after the final stop-bit sample (2 sync cycles after that sample on the pin).
- Async reset mid-frame: immediate return to IDLE; a partial frame is never flagged.

Decomposition:
- Package uart_pkg: parity-mode constants (PAR_NONE, PAR_ODD, PAR_EVEN) and the state enum encoding.
- One natural sub-module: uart_bit_sampler. Holds the synchroniser, falling-edge detect, tick counter and 3-sample majority, and outputs sample_strobe, sample_bit and bit_end to the frame FSM.

Test Plan:
- Default params, send 0xA5 8N1 at 16 clk/bit -> one rx_flag, rx_data = 0xA5, both errors 0, rx_addr 0 -> 1.
- PARITY_MODE = 2, DATA_BITS = 7: send 0x41 with parity 0, then 0x41 with parity 1 -> first clean; second rx_parity_err = 1, rx_addr unchanged.
- Low glitch of 3 cycles on idle rxd -> no rx_flag, busy returns low by tick MID+2.
- Stop bit forced 0 with line held low for 40 bit times -> exactly one rx_flag with rx_frame_err = 1; next valid frame 0x3C is received correctly after the line rises.
- Preload via 29999 clean frames (or force) with rx_addr = 29999, send frame -> rx_addr = 0; addr_clr asserted on the same cycle as rx_flag -> rx_addr = 0.
- Back-to-back frames 0x00, 0xFF with no idle gap, STOP_BITS = 2, CLKS_PER_BIT = 10 -> two flags, correct data; rst_n pulse mid-second frame -> no flag, all outputs 0.
